// File: rtl/uart_tx_arbiter_if.sv
// Requester and TX-controller handshake bundle for uart_tx_arbiter.
// The arbiter takes the slave view; client logic and the TX side take the master view.
interface uart_tx_arbiter_if #(
    parameter int NUM_REQ    = 4,
    parameter int DATA_WIDTH = 8
);
    logic [NUM_REQ-1:0]            req_valid;
    logic [NUM_REQ*DATA_WIDTH-1:0] req_data;
    logic [2*NUM_REQ-1:0]          req_parity;
    logic [2*NUM_REQ-1:0]          req_stop;
    logic [NUM_REQ-1:0]            req_ack;
    logic                          tx_ready;
    logic                          tx_valid_in;
    logic [DATA_WIDTH-1:0]         tx_data;
    logic [1:0]                    tx_parity;
    logic [1:0]                    tx_stop;
    logic                          tx_mode;

    modport master (
        output req_valid, req_data, req_parity, req_stop, tx_ready,
        input  req_ack, tx_valid_in, tx_data, tx_parity, tx_stop, tx_mode
    );

    modport slave (
        input  req_valid, req_data, req_parity, req_stop, tx_ready,
        output req_ack, tx_valid_in, tx_data, tx_parity, tx_stop, tx_mode
    );
endinterface

// File: rtl/uart_tx_arbiter.sv
// Round-robin scheduler sharing one UART TX path between NUM_REQ requesters,
// issuing one frame at a time and tracking completion/start timeout via tx_ready.
module uart_tx_arbiter #(
    parameter int NUM_REQ       = 4,
    parameter int DATA_WIDTH    = 8,
    parameter int START_TIMEOUT = 64
) (
    input  logic                       clk,
    input  logic                       reset,
    uart_tx_arbiter_if.slave           bus,
    output logic [$clog2(NUM_REQ)-1:0] grant_id,
    output logic                       busy,
    output logic                       frame_done,
    output logic                       start_err
);
    localparam int ID_W  = $clog2(NUM_REQ);
    localparam int CNT_W = $clog2(START_TIMEOUT);
    // The error fires on the cycle the count would step onto START_TIMEOUT-1,
    // which puts start_err exactly START_TIMEOUT cycles after tx_valid_in.
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(START_TIMEOUT - 2);
    localparam logic [ID_W-1:0]  ID_LAST  = ID_W'(NUM_REQ - 1);

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT_START,
        WAIT_DONE
    } state_t;

    state_t                  state;
    logic [ID_W-1:0]         ptr;
    logic [CNT_W-1:0]        cnt;
    logic                    tx_valid_q;
    logic [NUM_REQ-1:0]      ack_q;
    logic [DATA_WIDTH-1:0]   data_q;
    logic [1:0]              parity_q;
    logic [1:0]              stop_q;

    logic                    sel_found;
    logic [ID_W-1:0]         sel_id;
    logic [ID_W-1:0]         idx;
    logic [NUM_REQ-1:0]      sel_onehot;
    logic [DATA_WIDTH-1:0]   sel_data;
    logic [1:0]              sel_parity;
    logic [1:0]              sel_stop;

    always_comb begin
        sel_found = 1'b0;
        sel_id    = '0;
        idx       = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            idx = ID_W'((32'(ptr) + i) % NUM_REQ);
            if (!sel_found && bus.req_valid[idx]) begin
                sel_found = 1'b1;
                sel_id    = idx;
            end
        end
    end

    always_comb begin
        sel_onehot = '0;
        sel_data   = '0;
        sel_parity = '0;
        sel_stop   = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (ID_W'(i) == sel_id) begin
                sel_onehot[i] = 1'b1;
                sel_data      = bus.req_data[i*DATA_WIDTH +: DATA_WIDTH];
                sel_parity    = bus.req_parity[i*2 +: 2];
                sel_stop      = bus.req_stop[i*2 +: 2];
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            ptr        <= '0;
            cnt        <= '0;
            tx_valid_q <= 1'b0;
            ack_q      <= '0;
            data_q     <= '0;
            parity_q   <= '0;
            stop_q     <= '0;
            grant_id   <= '0;
            busy       <= 1'b0;
            frame_done <= 1'b0;
            start_err  <= 1'b0;
        end else begin
            tx_valid_q <= 1'b0;
            ack_q      <= '0;
            frame_done <= 1'b0;
            start_err  <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (bus.tx_ready && sel_found) begin
                        state      <= ISSUE;
                        grant_id   <= sel_id;
                        data_q     <= sel_data;
                        parity_q   <= sel_parity;
                        stop_q     <= sel_stop;
                        tx_valid_q <= 1'b1;
                        ack_q      <= sel_onehot;
                        busy       <= 1'b1;
                    end
                end
                ISSUE: begin
                    ptr   <= (grant_id == ID_LAST) ? '0 : grant_id + 1'b1;
                    cnt   <= '0;
                    state <= WAIT_START;
                end
                WAIT_START: begin
                    if (!bus.tx_ready) begin
                        state <= WAIT_DONE;
                    end else if (cnt == CNT_LAST) begin
                        start_err <= 1'b1;
                        busy      <= 1'b0;
                        state     <= IDLE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                WAIT_DONE: begin
                    if (bus.tx_ready) begin
                        frame_done <= 1'b1;
                        busy       <= 1'b0;
                        state      <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.tx_valid_in = tx_valid_q;
    assign bus.req_ack     = ack_q;
    assign bus.tx_data     = data_q;
    assign bus.tx_parity   = parity_q;
    assign bus.tx_stop     = stop_q;
    assign bus.tx_mode     = 1'b1;
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Self-checking bench for uart_tx_arbiter: vector table, directed corner sequences
// and randomized frames checked against a distance-based round-robin model.
module tb_uart_tx_arbiter;
    localparam int NR = 4;
    localparam int DW = 8;
    localparam int TO = 64;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic [1:0] grant_id;
    logic busy, frame_done, start_err;

    uart_tx_arbiter_if #(.NUM_REQ(NR), .DATA_WIDTH(DW)) bus ();

    uart_tx_arbiter #(
        .NUM_REQ(NR),
        .DATA_WIDTH(DW),
        .START_TIMEOUT(TO)
    ) dut (
        .clk(clk),
        .reset(reset),
        .bus(bus),
        .grant_id(grant_id),
        .busy(busy),
        .frame_done(frame_done),
        .start_err(start_err)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int mptr = 0;
    logic [DW-1:0] rd [NR];
    logic [1:0]    rp [NR];
    logic [1:0]    rs [NR];
    logic [DW-1:0] ed;
    logic [1:0]    ep, es;

    typedef struct {
        logic [NR-1:0] mask;
        logic [DW-1:0] base;
        int            exp_id;
    } vec_t;
    vec_t tbl [9];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Round-robin reference: the pending requester at the smallest forward distance from the pointer.
    function automatic int model_pick(input logic [NR-1:0] m, input int p);
        int best = -1;
        int bd = NR;
        for (int i = 0; i < NR; i++) begin
            if (m[i] && ((i - p + NR) % NR) < bd) begin
                bd = (i - p + NR) % NR;
                best = i;
            end
        end
        return best;
    endfunction

    task automatic drive_reqs(input logic [NR-1:0] mask);
        bus.req_valid = mask;
        for (int i = 0; i < NR; i++) begin
            bus.req_data[i*DW +: DW] = rd[i];
            bus.req_parity[i*2 +: 2] = rp[i];
            bus.req_stop[i*2 +: 2]   = rs[i];
        end
    endtask

    task automatic scramble(input int mode);
        if (mode == 1) begin
            bus.req_valid  = NR'($urandom);
            bus.req_data   = (NR*DW)'($urandom);
            bus.req_parity = (2*NR)'($urandom);
            bus.req_stop   = (2*NR)'($urandom);
        end else if (mode == 2) begin
            bus.req_data   = '1;
            bus.req_parity = '0;
            bus.req_stop   = '0;
        end
    endtask

    task automatic check_held();
        check("tx_data", 32'(bus.tx_data), 32'(ed));
        check("tx_parity", 32'(bus.tx_parity), 32'(ep));
        check("tx_stop", 32'(bus.tx_stop), 32'(es));
    endtask

    task automatic check_reset_outputs();
        check("rst_tx_valid_in", 32'(bus.tx_valid_in), 0);
        check("rst_req_ack", 32'(bus.req_ack), 0);
        check("rst_tx_data", 32'(bus.tx_data), 0);
        check("rst_tx_parity", 32'(bus.tx_parity), 0);
        check("rst_tx_stop", 32'(bus.tx_stop), 0);
        check("rst_grant_id", 32'(grant_id), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_frame_done", 32'(frame_done), 0);
        check("rst_start_err", 32'(start_err), 0);
        check("tx_mode", 32'(bus.tx_mode), 1);
    endtask

    task automatic do_reset();
        bus.tx_ready   = 1'b1;
        bus.req_valid  = '0;
        bus.req_data   = '0;
        bus.req_parity = '0;
        bus.req_stop   = '0;
        reset = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check_reset_outputs();
        reset = 1'b0;
        mptr = 0;
    endtask

    // Called on a negedge with the DUT idle; returns on the negedge where frame_done/start_err is seen.
    // drop_after < 0 models a TX controller that never starts.
    task automatic run_frame(input logic [NR-1:0] mask, input int exp_id, input int drop_after,
                             input int hold_low, input bit keep, input int scr);
        ed = rd[exp_id];
        ep = rp[exp_id];
        es = rs[exp_id];
        bus.tx_ready = 1'b1;
        drive_reqs(mask);
        @(negedge clk);
        check("tx_valid_in", 32'(bus.tx_valid_in), 1);
        check("req_ack", 32'(bus.req_ack), 32'(1) << exp_id);
        check("grant_id", 32'(grant_id), 32'(exp_id));
        check("busy_issue", 32'(busy), 1);
        check("frame_done_issue", 32'(frame_done), 0);
        check("start_err_issue", 32'(start_err), 0);
        check_held();
        if (!keep) bus.req_valid = bus.req_valid & ~(NR'(1) << exp_id);
        mptr = (exp_id + 1) % NR;
        if (drop_after >= 0) begin
            for (int c = 0; c < drop_after; c++) begin
                @(negedge clk);
                check("tx_valid_in_pulse", 32'(bus.tx_valid_in), 0);
                check("req_ack_pulse", 32'(bus.req_ack), 0);
                check("busy_wait_start", 32'(busy), 1);
                check_held();
                scramble(scr);
            end
            bus.tx_ready = 1'b0;
            for (int c = 0; c < hold_low; c++) begin
                @(negedge clk);
                check("busy_wait_done", 32'(busy), 1);
                check("frame_done_early", 32'(frame_done), 0);
                check("tx_valid_in_wait", 32'(bus.tx_valid_in), 0);
                check_held();
                scramble(scr);
            end
            bus.tx_ready = 1'b1;
            @(negedge clk);
            check("frame_done", 32'(frame_done), 1);
            check("start_err_on_done", 32'(start_err), 0);
            check("busy_after_done", 32'(busy), 0);
            check_held();
        end else begin
            for (int c = 0; c < TO - 1; c++) begin
                @(negedge clk);
                check("start_err_early", 32'(start_err), 0);
                check("frame_done_timeout", 32'(frame_done), 0);
                check("busy_timeout", 32'(busy), 1);
                check("tx_valid_in_timeout", 32'(bus.tx_valid_in), 0);
                check_held();
                scramble(scr);
            end
            @(negedge clk);
            check("start_err", 32'(start_err), 1);
            check("frame_done_none", 32'(frame_done), 0);
            check("busy_after_err", 32'(busy), 0);
            check_held();
        end
    endtask

    initial begin
        tbl[0] = '{4'b0101, 8'h20, 0};
        tbl[1] = '{4'b0101, 8'h30, 2};
        tbl[2] = '{4'b0101, 8'h40, 0};
        tbl[3] = '{4'b1000, 8'h50, 3};
        tbl[4] = '{4'b0110, 8'h60, 1};
        tbl[5] = '{4'b0011, 8'h70, 0};
        tbl[6] = '{4'b1111, 8'h80, 1};
        tbl[7] = '{4'b0010, 8'h90, 1};
        tbl[8] = '{4'b1001, 8'hA0, 3};

        do_reset();

        // Single requester 2, slow TX controller.
        for (int i = 0; i < NR; i++) begin rd[i] = 8'h00; rp[i] = 2'b00; rs[i] = 2'b00; end
        rd[2] = 8'hA5;
        run_frame(4'b0100, 2, 3, 100, 1'b0, 0);

        // All four held valid: strict rotation 0,1,2,3,0.
        do_reset();
        for (int i = 0; i < NR; i++) begin rd[i] = 8'h10 + 8'(i); rp[i] = 2'b00; rs[i] = 2'b00; end
        for (int k = 0; k < 5; k++) run_frame(4'b1111, k % NR, 2, 3, 1'b1, 0);

        // Vector table from a fresh pointer; includes invalid parity/stop passthrough.
        do_reset();
        for (int t = 0; t < 9; t++) begin
            for (int i = 0; i < NR; i++) begin
                rd[i] = tbl[t].base + 8'(i);
                rp[i] = 2'(i);
                rs[i] = 2'(3 - i);
            end
            run_frame(tbl[t].mask, tbl[t].exp_id, 1 + t % 3, 2 + t % 4, 1'b0, 0);
        end

        // Requester 1 inputs change mid-frame; outputs must hold.
        rd[1] = 8'h3C; rp[1] = 2'b10; rs[1] = 2'b01;
        run_frame(4'b0010, 1, 3, 20, 1'b0, 2);

        // Start timeout, then the still-pending requester 1 is served.
        for (int i = 0; i < NR; i++) begin rd[i] = 8'hC0 + 8'(i); rp[i] = 2'b01; rs[i] = 2'b00; end
        run_frame(4'b0011, 0, -1, 0, 1'b0, 0);
        run_frame(4'b0010, 1, 2, 4, 1'b0, 0);

        // tx_ready low blocks grants.
        bus.tx_ready = 1'b0;
        drive_reqs(4'b0101);
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            check("blocked_tx_valid_in", 32'(bus.tx_valid_in), 0);
            check("blocked_req_ack", 32'(bus.req_ack), 0);
        end
        run_frame(4'b0101, 2, 2, 3, 1'b0, 0);

        // Reset asserted in WAIT_DONE after granting 2 (pointer would be 3).
        rd[2] = 8'h5A;
        drive_reqs(4'b0100);
        @(negedge clk);
        check("pre_reset_grant", 32'(grant_id), 2);
        bus.req_valid = '0;
        @(negedge clk);
        @(negedge clk);
        bus.tx_ready = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("busy_before_reset", 32'(busy), 1);
        #2 reset = 1'b1;
        #1 check_reset_outputs();
        @(negedge clk);
        bus.tx_ready = 1'b1;
        reset = 1'b0;
        mptr = 0;
        for (int i = 0; i < NR; i++) begin rd[i] = 8'hE0 + 8'(i); rp[i] = 2'b10; rs[i] = 2'b01; end
        run_frame(4'b1010, 1, 2, 2, 1'b0, 0);

        // Randomized frames against the reference model.
        for (int n = 0; n < 40; n++) begin
            logic [NR-1:0] m;
            int drop;
            m = NR'($urandom_range(1, (1 << NR) - 1));
            for (int i = 0; i < NR; i++) begin
                rd[i] = DW'($urandom);
                rp[i] = 2'($urandom);
                rs[i] = 2'($urandom);
            end
            if ($urandom_range(0, 7) == 0) drop = -1;
            else drop = int'($urandom_range(1, 5));
            run_frame(m, model_pick(m, mptr), drop, int'($urandom_range(1, 12)),
                      1'($urandom), 1);
        end

        @(negedge clk);
        check("final_frame_done", 32'(frame_done), 0);
        check("final_start_err", 32'(start_err), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached, checks %0d errors %0d", checks, errors);
        $fatal(1, "watchdog");
    end
endmodule
